parity_stream_gen: RTL and testbench

Transmit-side companion of the even/odd classifier. Accepts one command describing a burst of bytes and a parity pattern, then drives the bytes onto a valid/ready byte stream. Each byte has its LSB forced to the commanded parity. Sits upstream of the parity-classifying receiver; used as a traffic source in bring-up and as a self-check partner in integration.

---
 rtl/parity_gen_pkg.sv | 8 +
 rtl/parity_stream_gen_if.sv | 15 +
 rtl/parity_stream_gen.sv | 73 +++++++
 tb/tb_parity_stream_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/parity_gen_pkg.sv
// parity_gen_pkg: shared mode/state enums and parity-bit selection for the parity stream generator
package parity_gen_pkg;
   typedef enum logic [1:0] {MODE_EVEN, MODE_ODD, MODE_ALT_EVEN, MODE_ALT_ODD} mode_t;
   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;
   function automatic logic par_bit(mode_t m, logic i0);
      return m == MODE_EVEN ? 1'b0 : m == MODE_ODD ? 1'b1 : m == MODE_ALT_EVEN ? i0 : ~i0;
   endfunction
endpackage

// File: rtl/parity_stream_gen_if.sv
// parity_stream_gen_if: command channel plus valid/ready byte stream of the parity generator
interface parity_stream_gen_if #(parameter int DATA_W = 8, parameter int LEN_W = 8);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_mode;
   logic [LEN_W-1:0]  cmd_len;
   logic [DATA_W-1:0] cmd_seed;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   modport master(input cmd_valid, cmd_mode, cmd_len, cmd_seed, out_ready,
                  output cmd_ready, out_valid, out_data);
   modport slave(output cmd_valid, cmd_mode, cmd_len, cmd_seed, out_ready,
                 input cmd_ready, out_valid, out_data);
endinterface

// File: rtl/parity_stream_gen.sv
// parity_stream_gen: emits a commanded burst of bytes whose LSB follows the commanded parity pattern
module parity_stream_gen
   import parity_gen_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   parity_stream_gen_if.master bus,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] sent_cnt,
   output logic             last_odd
);
   state_t            state;
   mode_t             mode;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  idx;
   logic [LEN_W-1:0]  idx_n;
   logic [DATA_W-2:0] seed_hi;
   logic              xfer;
   assign bus.cmd_ready = state == ST_IDLE;
   assign xfer          = bus.out_valid && bus.out_ready;
   assign idx_n         = idx + LEN_W'(1);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state         <= ST_IDLE;
         mode          <= MODE_EVEN;
         len           <= '0;
         idx           <= '0;
         seed_hi       <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         sent_cnt      <= '0;
         last_odd      <= 1'b0;
      end else
         case (state)
            ST_IDLE: if (bus.cmd_valid) begin
               mode          <= mode_t'(bus.cmd_mode);
               len           <= bus.cmd_len;
               seed_hi       <= bus.cmd_seed[DATA_W-1:1];
               idx           <= '0;
               sent_cnt      <= '0;
               busy          <= 1'b1;
               bus.out_data  <= {bus.cmd_seed[DATA_W-1:1], par_bit(mode_t'(bus.cmd_mode), 1'b0)};
               bus.out_valid <= bus.cmd_len != '0;
               done          <= bus.cmd_len == '0;
               state         <= bus.cmd_len != '0 ? ST_SEND : ST_DONE;
            end
            ST_SEND: if (xfer) begin
               sent_cnt <= sent_cnt + LEN_W'(1);
               last_odd <= bus.out_data[0];
               if (idx == len - LEN_W'(1)) begin
                  bus.out_valid <= 1'b0;
                  done          <= 1'b1;
                  state         <= ST_DONE;
               end else begin
                  // next byte is prepared on the transfer edge so the stream never bubbles
                  idx          <= idx_n;
                  bus.out_data <= {seed_hi + (DATA_W-1)'(idx_n), par_bit(mode, idx_n[0])};
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
endmodule

// File: tb/tb_parity_stream_gen.sv
// tb_parity_stream_gen: randomized bursts checked against a byte-list model of the parity generator
module tb_parity_stream_gen;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       busy, done, last_odd;
   logic [7:0] sent_cnt;
   int         vectors = 0;
   int         miscompares = 0;

   parity_stream_gen_if #(.DATA_W(8), .LEN_W(8)) bus ();

   parity_stream_gen #(.DATA_W(8), .LEN_W(8)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .busy(busy), .done(done), .sent_cnt(sent_cnt), .last_odd(last_odd)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      bus.cmd_valid = 0; bus.cmd_mode = 0; bus.cmd_len = 0; bus.cmd_seed = 0; bus.out_ready = 0;
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (bus.cmd_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || busy !== 1'b0 ||
          done !== 1'b0 || sent_cnt !== 8'h00 || last_odd !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_values: got rdy=%b vld=%b data=%h busy=%b done=%b cnt=%0d odd=%b want 1 0 00 0 0 0 0",
                  bus.cmd_ready, bus.out_valid, bus.out_data, busy, done, sent_cnt, last_odd);
      end
      reset = 0;
   endtask

   task automatic test_burst(input logic [1:0] mode, input logic [7:0] len, input logic [7:0] seed,
                             input int hold, input int stall_pct);
      logic [7:0] exp_q[$];
      int n = 0;
      int cyc = 0;
      for (int i = 0; i < int'(len); i++) begin
         int hi = (int'(seed) / 2 + i) % 128;
         int p = mode == 2'd0 ? 0 : mode == 2'd1 ? 1 : (i % 2) ^ int'(mode == 2'd3);
         exp_q.push_back(8'(hi * 2 + p));
      end
      vectors++;
      if (bus.cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL cmd_ready_idle: got %b want 1", bus.cmd_ready);
      end
      bus.cmd_valid = 1; bus.cmd_mode = mode; bus.cmd_len = len; bus.cmd_seed = seed;
      bus.out_ready = 1'($urandom);
      @(posedge clk); #1;
      bus.cmd_valid = 0;
      while (n < int'(len) && cyc < 5000) begin
         vectors++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[n] || done !== 1'b0 || busy !== 1'b1 ||
             sent_cnt !== 8'(n) || bus.cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_byte%0d: got vld=%b data=%h done=%b busy=%b cnt=%0d rdy=%b want 1 %h 0 1 %0d 0",
                     n, bus.out_valid, bus.out_data, done, busy, sent_cnt, bus.cmd_ready, exp_q[n], n);
         end
         bus.out_ready = cyc < hold ? 1'b0 : 1'($urandom_range(99) >= stall_pct);
         @(posedge clk); #1;
         cyc++;
         if (bus.out_ready) begin
            n++;
            vectors++;
            if (last_odd !== exp_q[n-1][0]) begin
               miscompares++;
               $display("FAIL last_odd%0d: got %b want %b", n - 1, last_odd, exp_q[n-1][0]);
            end
         end
      end
      vectors++;
      if (cyc >= 5000) begin
         miscompares++;
         $display("FAIL burst_timeout: got %0d bytes want %0d", n, len);
      end
      vectors++;
      if (done !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b1 || sent_cnt !== len) begin
         miscompares++;
         $display("FAIL burst_done: got done=%b vld=%b busy=%b cnt=%0d want 1 0 1 %0d",
                  done, bus.out_valid, busy, sent_cnt, len);
      end
      bus.out_ready = 1'($urandom);
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.out_valid !== 1'b0 || sent_cnt !== len) begin
         miscompares++;
         $display("FAIL burst_idle: got done=%b busy=%b rdy=%b vld=%b cnt=%0d want 0 0 1 0 %0d",
                  done, busy, bus.cmd_ready, bus.out_valid, sent_cnt, len);
      end
   endtask

   task automatic test_cmd_ignored();
      bus.cmd_valid = 1; bus.cmd_mode = 2'd0; bus.cmd_len = 8'd3; bus.cmd_seed = 8'h20; bus.out_ready = 0;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         bus.cmd_valid = 1; bus.cmd_mode = 2'($urandom); bus.cmd_len = 8'($urandom); bus.cmd_seed = 8'($urandom);
         @(posedge clk); #1;
         vectors++;
         if (bus.cmd_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h20) begin
            miscompares++;
            $display("FAIL cmd_ignored%0d: got rdy=%b vld=%b data=%h want 0 1 20",
                     k, bus.cmd_ready, bus.out_valid, bus.out_data);
         end
      end
      bus.cmd_valid = 0;
      bus.out_ready = 1;
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (bus.out_data !== 8'(8'h20 + 2 * k)) begin
            miscompares++;
            $display("FAIL ignored_data%0d: got %h want %h", k, bus.out_data, 8'(8'h20 + 2 * k));
         end
         @(posedge clk); #1;
      end
      vectors++;
      if (done !== 1'b1 || sent_cnt !== 8'd3) begin
         miscompares++;
         $display("FAIL ignored_done: got done=%b cnt=%0d want 1 3", done, sent_cnt);
      end
      bus.out_ready = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bus.cmd_valid = 1; bus.cmd_mode = 2'd2; bus.cmd_len = 8'd5; bus.cmd_seed = 8'h40; bus.out_ready = 1;
      @(posedge clk); #1;
      bus.cmd_valid = 0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (sent_cnt !== 8'd2) begin
         miscompares++;
         $display("FAIL pre_reset_cnt: got %0d want 2", sent_cnt);
      end
      #2 reset = 1;
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.cmd_ready !== 1'b1 || sent_cnt !== 8'd0 ||
          done !== 1'b0 || last_odd !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid: got vld=%b busy=%b rdy=%b cnt=%0d done=%b odd=%b want 0 0 1 0 0 0",
                  bus.out_valid, busy, bus.cmd_ready, sent_cnt, done, last_odd);
      end
      @(posedge clk); #1;
      reset = 0;
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_no_done: got %b want 0", done);
      end
      test_burst(2'($urandom), 8'($urandom_range(1, 6)), 8'($urandom), 0, 20);
   endtask

   initial begin
      test_reset();
      test_burst(2'd1, 8'd3, 8'h10, 0, 0);
      test_burst(2'd2, 8'd4, 8'h00, 0, 0);
      test_burst(2'd0, 8'd2, 8'h00, 5, 0);
      test_burst(2'($urandom), 8'd0, 8'($urandom), 0, 0);
      test_burst(2'd3, 8'd2, 8'hFE, 0, 0);
      test_cmd_ignored();
      test_reset_mid();
      test_burst(2'($urandom), 8'd255, 8'($urandom), 0, 30);
      for (int r = 0; r < 20; r++)
         test_burst(2'($urandom), 8'($urandom_range(1, 20)), 8'($urandom), int'($urandom_range(0, 3)), 40);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
